hs_master_fifo: RTL

HS_MASTER_FIFO -- requirements
Module: hs_master_fifo

---
 rtl/hs_master_fifo_if.sv | 37 +++
 rtl/hs_master_fifo.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hs_master_fifo_if.sv
// Handshake bundle for hs_master_fifo: source strobe in, registered valid/data out, status flags.
// Macro DROP_CNT_EN adds the 8-bit drop_cnt status signal.
interface hs_master_fifo_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) ();
   localparam int LW = $clog2(DEPTH) + 1;

   logic             data_valid;
   logic [WIDTH-1:0] outside_data;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic             valid;
   logic [LW-1:0]    level;
   logic             full;
   logic             ovf;
   logic             ovf_clr;
`ifdef DROP_CNT_EN
   logic [7:0]       drop_cnt;
`endif

   modport master (
      input  data_valid, outside_data, ready, ovf_clr,
`ifdef DROP_CNT_EN
      output drop_cnt,
`endif
      output data, valid, level, full, ovf
   );

   modport slave (
      output data_valid, outside_data, ready, ovf_clr,
`ifdef DROP_CNT_EN
      input  drop_cnt,
`endif
      input  data, valid, level, full, ovf
   );
endinterface

// File: rtl/hs_master_fifo.sv
// Small FIFO that presents its head word on a registered valid/data port; overflowing pushes are dropped.
// Macro DROP_CNT_EN adds a saturating 8-bit count of dropped words.
module hs_master_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   hs_master_fifo_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];
   localparam logic [AW:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] LVL_ZERO = '0;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_level;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_ovf;

   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [AW-1:0]    w_rd_ptr_nxt;

   assign w_full       = (r_level == LVL_FULL);
   assign w_pop        = r_valid & bus.ready;
   assign w_push       = bus.data_valid & (~w_full | w_pop);
   assign w_drop       = bus.data_valid & w_full & ~w_pop;
   assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

   // Storage holds every word, including the one mirrored in r_data; never read before written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.outside_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // Next head comes from storage when one remains behind the popped word,
   // otherwise straight from the source so an empty FIFO has one cycle of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (w_pop && (r_level > LVL_ONE)) begin
         r_data  <= r_mem[w_rd_ptr_nxt];
         r_valid <= 1'b1;
      end else if (w_push && ((r_level == LVL_ZERO) || w_pop)) begin
         r_data  <= bus.outside_data;
         r_valid <= 1'b1;
      end else if (w_pop) begin
         r_valid <= 1'b0;
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

`ifdef DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_drop && bus.ovf_clr) begin
         r_drop_cnt <= 8'd1;
      end else if (w_drop) begin
         if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end else if (bus.ovf_clr) begin
         r_drop_cnt <= '0;
      end
   end

   assign bus.drop_cnt = r_drop_cnt;
`endif

   assign bus.data  = r_data;
   assign bus.valid = r_valid;
   assign bus.level = r_level;
   assign bus.full  = w_full;
   assign bus.ovf   = r_ovf;

endmodule
